// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding and default frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        CHECK  = 3'd4,
        STOP   = 3'd5
    } uart_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Baud-tick and bit counters for the receive FSM; emits mid-bit, bit-end and last-bit strobes.
module uart_rx_bit_timer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    input  logic baud_tick,
    input  logic bit_count_en,
    output logic mid_bit,
    output logic bit_end,
    output logic last_bit
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] bit_cnt;
    logic          tick_en;

    // Ticks only count while the FSM is out of IDLE.
    assign tick_en  = enable & baud_tick;
    assign mid_bit  = tick_en && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
    assign bit_end  = tick_en && (tick_cnt == TW'(OVERSAMPLE - 1));
    assign last_bit = bit_end && (bit_cnt == BW'(DATA_BITS - 1));

    // Tick counter; OVERSAMPLE is a power of two so the natural wrap marks each bit period.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            tick_cnt <= '0;
        else if (clear)
            tick_cnt <= '0;
        else if (tick_en)
            tick_cnt <= tick_cnt + 1'b1;
    end

    // Data-bit counter, advanced on each sample point while receiving data.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            bit_cnt <= '0;
        else if (clear)
            bit_cnt <= '0;
        else if (bit_end && bit_count_en)
            bit_cnt <= bit_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start detect, bit timing, SIPO/parity-checker control, frame status.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE    = UART_OVERSAMPLE,
    parameter int DATA_BITS     = UART_DATA_BITS,
    parameter int PARITY_EN     = 1,
    parameter int CHECK_LATENCY = 2
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic rx_in,
    input  logic baud_tick_in,
    input  logic rx_enable_in,
    input  logic parity_check_in,
    output logic sipo_shift_enable_out,
    output logic sipo_bit_out,
    output logic parity_bit_out,
    output logic paritybit_check_enable_out,
    output logic frame_valid_out,
    output logic parity_error_out,
    output logic framing_error_out,
    output logic busy_out
);

    localparam int CW = $clog2(CHECK_LATENCY + 1) + 1;

    uart_state_t   state, state_d;
    logic          rx_meta, rx_s, rx_prev;
    logic          start_edge;
    logic [CW-1:0] chk_cnt;
    logic          check_done;
    logic          parity_ok;
    logic          mid_bit, bit_end, last_bit;
    logic          tmr_clear;

    logic shift_d, sbit_d, pbit_d, cen_d, fv_d, perr_d, ferr_d, busy_d;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Only a genuine 1->0 transition arms a frame; a line stuck low does not.
    assign start_edge = rx_prev & ~rx_s;
    assign check_done = (state == CHECK) && (chk_cnt == CW'(CHECK_LATENCY));

    // Counter restarts on frame start and again at the confirmed mid start bit.
    assign tmr_clear = ((state == IDLE)  && (state_d == START)) ||
                       ((state == START) && (state_d == DATA));

    uart_rx_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_BITS  (DATA_BITS)
    ) u_timer (
        .Clk          (Clk),
        .reset_n      (reset_n),
        .clear        (tmr_clear),
        .enable       (state != IDLE),
        .baud_tick    (baud_tick_in),
        .bit_count_en (state == DATA),
        .mid_bit      (mid_bit),
        .bit_end      (bit_end),
        .last_bit     (last_bit)
    );

    // State register.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next-state logic; a dropped enable overrides everything and parks in IDLE.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start_edge) state_d = START;
            START:   if (mid_bit)    state_d = rx_s ? IDLE : DATA;
            DATA:    if (last_bit)   state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end)    state_d = CHECK;
            CHECK:   if (check_done) state_d = STOP;
            STOP:    if (bit_end)    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
        if (!rx_enable_in)
            state_d = IDLE;
    end

    // Cycle index within CHECK; baud ticks keep counting in the timer meanwhile.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            chk_cnt <= '0;
        else if (state != CHECK)
            chk_cnt <= '0;
        else
            chk_cnt <= chk_cnt + 1'b1;
    end

    // Parity checker result captured at the end of the check window.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            parity_ok <= 1'b0;
        else if ((state == IDLE) && (state_d == START))
            parity_ok <= 1'b0;
        else if (check_done && rx_enable_in)
            parity_ok <= parity_check_in;
    end

    // Output decode: next values for the registered outputs.
    always_comb begin
        shift_d = rx_enable_in && (state == DATA) && bit_end;
        sbit_d  = shift_d ? rx_s : sipo_bit_out;

        pbit_d = parity_bit_out;
        if ((state == IDLE) && (state_d == START))
            pbit_d = 1'b0;
        if (rx_enable_in && (state == PARITY) && bit_end)
            pbit_d = rx_s;

        // Enable covers CHECK cycles 0 .. CHECK_LATENCY-1.
        cen_d = 1'b0;
        if (state_d == CHECK) begin
            if (state != CHECK)
                cen_d = (CHECK_LATENCY > 0);
            else
                cen_d = (int'(chk_cnt) + 1 < CHECK_LATENCY);
        end

        fv_d   = rx_enable_in && (state == STOP) && bit_end;
        ferr_d = fv_d && !rx_s;
        perr_d = fv_d && (PARITY_EN != 0) && !parity_ok;
        busy_d = (state_d != IDLE);
    end

    // Output registers.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sipo_shift_enable_out      <= 1'b0;
            sipo_bit_out               <= 1'b0;
            parity_bit_out             <= 1'b0;
            paritybit_check_enable_out <= 1'b0;
            frame_valid_out            <= 1'b0;
            parity_error_out           <= 1'b0;
            framing_error_out          <= 1'b0;
            busy_out                   <= 1'b0;
        end else begin
            sipo_shift_enable_out      <= shift_d;
            sipo_bit_out               <= sbit_d;
            parity_bit_out             <= pbit_d;
            paritybit_check_enable_out <= cen_d;
            frame_valid_out            <= fv_d;
            parity_error_out           <= perr_d;
            framing_error_out          <= ferr_d;
            busy_out                   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: serial frames against a frame-level reference model.
module tb_uart_rx_controller;

    localparam int OS     = 16;
    localparam int DB     = 8;
    localparam int LAT    = 2;
    localparam int TDIV   = 4;
    localparam int BITCLK = OS * TDIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic en = 1'b1;
    logic pchk = 1'b1;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;

    logic shift1, sbit1, pbit1, cen1, fv1, perr1, ferr1, busy1;
    logic shift2, sbit2, pbit2, cen2, fv2, perr2, ferr2, busy2;

    always #5 clk = ~clk;

    uart_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_EN(1), .CHECK_LATENCY(LAT)) u_dut (
        .Clk(clk), .reset_n(rst_n), .rx_in(rx1), .baud_tick_in(tick), .rx_enable_in(en),
        .parity_check_in(pchk), .sipo_shift_enable_out(shift1), .sipo_bit_out(sbit1),
        .parity_bit_out(pbit1), .paritybit_check_enable_out(cen1), .frame_valid_out(fv1),
        .parity_error_out(perr1), .framing_error_out(ferr1), .busy_out(busy1));

    uart_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_EN(0), .CHECK_LATENCY(LAT)) u_dut_np (
        .Clk(clk), .reset_n(rst_n), .rx_in(rx2), .baud_tick_in(tick), .rx_enable_in(en),
        .parity_check_in(pchk), .sipo_shift_enable_out(shift2), .sipo_bit_out(sbit2),
        .parity_bit_out(pbit2), .paritybit_check_enable_out(cen2), .frame_valid_out(fv2),
        .parity_error_out(perr2), .framing_error_out(ferr2), .busy_out(busy2));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed traffic: shifted bits, frame reports {parity_bit, parity_err, framing_err}.
    logic       q1[$];
    logic       q2[$];
    logic [2:0] f1[$];
    logic [2:0] f2[$];
    int cnt_cen1 = 0;
    int cnt_cen2 = 0;
    int wid_err = 0;
    logic sh1_d = 1'b0, sh2_d = 1'b0, fv1_d = 1'b0, fv2_d = 1'b0;

    always @(negedge clk) begin
        if (shift1) q1.push_back(sbit1);
        if (shift2) q2.push_back(sbit2);
        if (fv1) f1.push_back({pbit1, perr1, ferr1});
        if (fv2) f2.push_back({pbit2, perr2, ferr2});
        if (cen1) cnt_cen1 <= cnt_cen1 + 1;
        if (cen2) cnt_cen2 <= cnt_cen2 + 1;
        if ((shift1 && sh1_d) || (shift2 && sh2_d) || (fv1 && fv1_d) || (fv2 && fv2_d))
            wid_err <= wid_err + 1;
        sh1_d <= shift1;
        sh2_d <= shift2;
        fv1_d <= fv1;
        fv2_d <= fv2;
    end

    // Baud tick: one clk high every TDIV clks.
    initial begin : tickgen
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (c == TDIV - 1);
            c = (c + 1) % TDIV;
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive n line bits LSB first, one bit period each.
    task automatic send(input bit sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) rx2 = bits[i];
            else     rx1 = bits[i];
            wclk(BITCLK);
        end
    endtask

    function automatic logic [15:0] mkf(input logic [7:0] d, input bit pe, input logic p, input logic stop);
        if (pe) return {5'b0, stop, p, d, 1'b0};
        return {6'b0, stop, d, 1'b0};
    endfunction

    // Send one complete frame and compare everything it produced with the frame rules.
    task automatic rx_frame(input string tag, input bit sel, input logic [7:0] d,
                            input logic p, input logic stop, input logic ok);
        int qb, fb, cb, nq, nf;
        logic got;
        logic [2:0] fl;
        bit pe;
        pe = !sel;
        qb = sel ? q2.size() : q1.size();
        fb = sel ? f2.size() : f1.size();
        cb = sel ? cnt_cen2 : cnt_cen1;
        pchk = ok;
        send(sel, mkf(d, pe, p, stop), pe ? 11 : 10);
        nq = (sel ? q2.size() : q1.size()) - qb;
        chk({tag, " nbits"}, nq, DB);
        for (int i = 0; i < DB; i++) begin
            if (i < nq) begin
                got = sel ? q2[qb + i] : q1[qb + i];
                chk($sformatf("%s bit%0d", tag, i), got, (d >> i) & 8'd1);
            end
        end
        nf = (sel ? f2.size() : f1.size()) - fb;
        chk({tag, " nframes"}, nf, 1);
        if (nf > 0) begin
            fl = sel ? f2[fb] : f1[fb];
            chk({tag, " parity_err"}, fl[1], pe && !ok);
            chk({tag, " framing_err"}, fl[0], !stop);
            if (pe) chk({tag, " parity_bit"}, fl[2], p);
        end
        chk({tag, " check_cycles"}, (sel ? cnt_cen2 : cnt_cen1) - cb, pe ? LAT : 0);
    endtask

    initial begin
        int qb, fb;
        logic [7:0] d;
        logic p, stop, bad;

        // Reset state
        wclk(3);
        chk("reset out1", {shift1, sbit1, pbit1, cen1, fv1, perr1, ferr1, busy1}, 0);
        chk("reset out2", {shift2, sbit2, pbit2, cen2, fv2, perr2, ferr2, busy2}, 0);
        rst_n = 1'b1;
        wclk(BITCLK);

        // Clean frame, good parity
        rx_frame("a5", 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
        wclk(BITCLK);

        // Checker reports mismatch
        rx_frame("01", 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
        wclk(BITCLK);

        // Framing error, then a long low line must not start a frame
        rx_frame("3c", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        qb = q1.size();
        fb = f1.size();
        wclk(40 * BITCLK);
        chk("lowline shifts", q1.size() - qb, 0);
        chk("lowline frames", f1.size() - fb, 0);
        chk("lowline busy", busy1, 0);
        rx1 = 1'b1;
        wclk(BITCLK);
        d = 8'($urandom);
        rx_frame("post_ferr", 1'b0, d, ^d, 1'b1, 1'b1);
        wclk(BITCLK);

        // Glitch shorter than half a bit
        qb = q1.size();
        fb = f1.size();
        rx1 = 1'b0;
        wclk(8);
        chk("glitch busy_hi", busy1, 1);
        wclk(4);
        rx1 = 1'b1;
        wclk(36);
        chk("glitch busy_lo", busy1, 0);
        wclk(BITCLK);
        chk("glitch shifts", q1.size() - qb, 0);
        chk("glitch frames", f1.size() - fb, 0);

        // Reset mid-frame after four data bits
        qb = q1.size();
        send(1'b0, mkf(8'hFF, 1'b1, 1'b0, 1'b1), 5);
        wclk(BITCLK / 4);
        chk("midrst shifts", q1.size() - qb, 4);
        chk("midrst busy_pre", busy1, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst out1", {shift1, sbit1, pbit1, cen1, fv1, perr1, ferr1, busy1}, 0);
        wclk(4);
        rx1 = 1'b1;
        rst_n = 1'b1;
        wclk(BITCLK);
        rx_frame("ff", 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
        wclk(BITCLK);

        // Enable dropped during DATA
        d = 8'($urandom);
        qb = q1.size();
        fb = f1.size();
        send(1'b0, mkf(d, 1'b1, ^d, 1'b1), 4);
        wclk(BITCLK / 4);
        en = 1'b0;
        wclk(1);
        chk("abort busy", busy1, 0);
        chk("abort pulses", {shift1, cen1, fv1}, 0);
        send(1'b0, mkf(d, 1'b1, ^d, 1'b1) >> 4, 7);
        wclk(BITCLK);
        chk("abort shifts", q1.size() - qb, 3);
        for (int i = 0; i < 3; i++)
            if (qb + i < q1.size()) chk($sformatf("abort bit%0d", i), q1[qb + i], (d >> i) & 8'd1);
        chk("abort frames", f1.size() - fb, 0);
        en = 1'b1;
        wclk(BITCLK);

        // No-parity instance: check enable never asserts, parity_error stays low
        rx_frame("np55", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        wclk(BITCLK);

        // Randomized frames on both instances
        for (int k = 0; k < 10; k++) begin
            d    = 8'($urandom);
            bad  = ($urandom_range(0, 3) == 0);
            p    = (^d) ^ bad;
            stop = ($urandom_range(0, 4) != 0);
            rx_frame($sformatf("rnd%0d", k), (k % 3) == 2, d, p, stop, !bad);
            rx1 = 1'b1;
            rx2 = 1'b1;
            wclk(BITCLK);
        end

        chk("pulse width", wid_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Sequencing FSM for the UART receive path. It detects the start bit on the serial line and times every bit from an oversampling baud tick. It drives the external SIPO shift register and the receiver parity-bit checker, then reports each completed frame with parity and framing status. It sits between the baud generator and the SIPO/parity datapath, and is the only block that asserts their enables.

## Interface
Parameters:
- OVERSAMPLE, 16: baud ticks per bit; power of two, ≥4.
- DATA_BITS, 8: data bits per frame; 5–8.
- PARITY_EN, 1: 1 = frame carries an even-parity bit after the data bits.
- CHECK_LATENCY, 2: Clk cycles the parity checker enable is held before its result is sampled.

Ports:
- Clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_in  in  1  raw serial line; idle high; synchronized internally.
- baud_tick_in  in  1  one-Clk pulse at OVERSAMPLE × baud rate.
- rx_enable_in  in  1  receiver enable; low aborts and holds IDLE.
- parity_check_in  in  1  result from the parity checker; 1 = parity matched.
- sipo_shift_enable_out  out  1  one-cycle pulse per data bit.
- sipo_bit_out  out  1  sampled data bit; valid when the shift pulse is high.
- parity_bit_out  out  1  sampled parity bit; held from PARITY sample until the next frame start.
- paritybit_check_enable_out  out  1  parity checker enable.
- frame_valid_out  out  1  one-cycle pulse at the end of every completed frame.
- parity_error_out  out  1  valid with frame_valid_out.
- framing_error_out  out  1  valid with frame_valid_out.
- busy_out  out  1  high in any state other than IDLE.

## Operation
- rx_in passes through a 2-flop synchronizer that resets to 1. All logic uses the synchronized value rx_s.
- States are IDLE, START, DATA, PARITY, CHECK and STOP.
- IDLE: when rx_enable_in=1 and rx_s falls from 1 to 0, clear tick_cnt and go to START.
- START: count baud ticks. At tick OVERSAMPLE/2 (mid start bit):
  - If rx_s=0, clear tick_cnt and bit_cnt, then go to DATA.
  - If rx_s=1, it is a false start; return to IDLE with no outputs.
- DATA: at every OVERSAMPLE-th tick, sample rx_s, pulse sipo_shift_enable_out, and increment bit_cnt. Data arrives LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: at the OVERSAMPLE-th tick, latch rx_s into parity_bit_out and go to CHECK.
- CHECK: lasts CHECK_LATENCY+1 Clk cycles.
  - paritybit_check_enable_out is high for the first CHECK_LATENCY cycles.
  - At the end of the last cycle, latch parity_ok = parity_check_in, then go to STOP.
  - tick_cnt keeps counting baud ticks throughout CHECK.
- STOP: at the OVERSAMPLE-th tick counted from the previous sample point, sample rx_s.
  - Pulse frame_valid_out.
  - framing_error_out = !rx_s.
  - parity_error_out = PARITY_EN & !parity_ok.
  - Go to IDLE. A low line after a framing error does not start a new frame; IDLE re-arms only on a fresh 1→0 edge.
- When PARITY_EN=0, parity_error_out is always 0 and CHECK is never entered.
- When rx_enable_in=0 in any state, go to IDLE on the next edge. All pulses and enables deassert, and no frame_valid_out is produced.
- When reset_n is low, including mid-frame: state is IDLE, counters are 0, and every output is 0.

## Timing
- Reset value of every output is 0. The synchronizer flops reset to 1.
- All outputs are registered.
- rx_in to rx_s latency is 2 Clk cycles.
- A sample is taken on the edge where a counted baud_tick_in is high. The resulting pulse appears in the following cycle:
  - sipo_shift_enable_out, with sipo_bit_out.
  - frame_valid_out, with both error flags.
- Each of these pulses is exactly one Clk cycle wide.
- Required input spacing: baud ticks at least CHECK_LATENCY+2 Clk cycles apart, so that CHECK completes before the next tick.
- Ticks that arrive in IDLE are ignored. Counting starts only on the START transition.

## Structure
- Shared package uart_pkg holds the following, for reuse by the TX controller:
  - The state enum: IDLE, START, DATA, PARITY, CHECK, STOP.
  - The default constants OVERSAMPLE and DATA_BITS.
- One sub-module, uart_rx_bit_timer:
  - Contains tick_cnt and bit_cnt.
  - Has clear/enable inputs.
  - Produces mid_bit, bit_end and last_bit strobes.
- The FSM, synchronizer and output registers live in the top module.

## Test plan
- Frame 0xA5 with parity 0 and stop 1, at OVERSAMPLE=16 with ticks every 4 Clk → 8 shift pulses with bits 1,0,1,0,0,1,0,1, one check window with the enable high 2 cycles, then frame_valid_out=1, parity_error_out=0, framing_error_out=0.
- Frame 0x01 with parity bit 0, and parity_check_in driven 0 in CHECK → frame_valid_out=1, parity_error_out=1.
- Frame 0x3C with stop bit 0 → frame_valid_out=1, framing_error_out=1. A line held low for 40 further bit times produces no new frame; the next frame after the line returns high is received correctly.
- Glitch: rx_in low for 3 ticks, then high → no shift pulse, busy_out returns to 0 by the mid start-bit sample.
- reset_n pulsed low after the 4th data bit → all outputs 0 immediately. The next complete frame, 0xFF, is received with no errors.
- rx_enable_in dropped during DATA → IDLE on the next edge and no frame_valid_out. With PARITY_EN=0, frame 0x55 → paritybit_check_enable_out never asserts.
